// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pkg
// Description : Shared types and constants for the FIFO read-side streamer.
//               Defines the streamer FSM state encoding, the skid buffer
//               depth and the width of the buffer occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int SKID_DEPTH = 2;
    // Occupancy must represent 0..SKID_DEPTH inclusive.
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_skid
// Description : Two-entry in-order skid buffer. Entry 0 is always the head;
//               a pop shifts entry 1 down. Push and pop in the same cycle
//               keep the occupancy unchanged while preserving order.
// Ports       : clk, rst    - clock, asynchronous active-high reset
//               clear       - drop all entries (priority over push/pop)
//               push, din   - write din at the tail
//               pop         - remove the head (only when occ != 0)
//               head        - current head word
//               occ         - number of valid entries, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [DW-1:0]    din,
    input  logic             pop,
    output logic [DW-1:0]    head,
    output logic [OCC_W-1:0] occ
);

    localparam logic [OCC_W-1:0] C_OCC0 = OCC_W'(0);
    localparam logic [OCC_W-1:0] C_OCC1 = OCC_W'(1);
    localparam logic [OCC_W-1:0] C_FULL = OCC_W'(SKID_DEPTH);

    logic [DW-1:0]    r_ent0;
    logic [DW-1:0]    r_ent1;
    logic [OCC_W-1:0] r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= '0;
        end else if (clear) begin
            r_occ <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_occ == C_OCC0) begin
                        r_ent0 <= din;
                        r_occ  <= C_OCC1;
                    end else if (r_occ == C_OCC1) begin
                        r_ent1 <= din;
                        r_occ  <= C_FULL;
                    end
                    // A push into a full buffer cannot occur: the read
                    // enable reserves a slot before the word is requested.
                end
                2'b01: begin
                    if (r_occ != C_OCC0) begin
                        r_ent0 <= r_ent1;
                        r_occ  <= r_occ - C_OCC1;
                    end
                end
                2'b11: begin
                    if (r_occ == C_OCC1) begin
                        r_ent0 <= din;
                    end else if (r_occ == C_FULL) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= din;
                    end else begin
                        // Pop of an empty buffer is a no-op; keep the push.
                        r_ent0 <= din;
                        r_occ  <= C_OCC1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = r_ent0;
    assign occ  = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_streamer
// Description : Read-side drain stage for a dual-clock FIFO. Issues FIFO
//               reads while a slot is guaranteed for the word one cycle
//               later, buffers words in a 2-entry skid buffer and presents
//               them as a valid/ready stream. Keeps saturating transfer and
//               stall counters.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               enable, flush        - read enable, level-sensitive discard
//               fifo_empty/dout/re   - FIFO read interface (1-cycle latency)
//               m_valid/ready/data   - output stream
//               busy                 - FSM not in IDLE
//               xfer_cnt, stall_cnt  - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_streamer
    import fifo_rd_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_re,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    rd_state_t        r_state;
    logic             r_infl;
    logic [CNT_W-1:0] r_xfer;
    logic [CNT_W-1:0] r_stall;

    logic [OCC_W-1:0] w_occ;
    logic             w_pop;
    logic             w_push;
    logic [2:0]       w_level;
    logic [2:0]       w_limit;
    logic             w_pending;

    assign m_valid   = (w_occ != '0);
    assign w_pop     = m_valid & m_ready;
    assign w_push    = r_infl & ~flush;
    assign w_level   = 3'(w_occ) + 3'(r_infl);
    assign w_pending = (w_level != 3'd0);
    // occ + infl - pop < DEPTH, rearranged to avoid unsigned underflow.
    assign w_limit   = 3'(SKID_DEPTH) + 3'(w_pop);
    // Gated by rst so the output sits at zero for the whole reset interval.
    assign fifo_re   = ~rst & enable & ~flush & ~fifo_empty & (w_level < w_limit);

    fifo_rd_skid #(
        .DW (DW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (w_push),
        .din   (fifo_dout),
        .pop   (w_pop),
        .head  (m_data),
        .occ   (w_occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_infl <= 1'b0;
        end else begin
            r_infl <= fifo_re;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (flush) begin
            r_state <= enable ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE:    if (enable) r_state <= RUN;
                RUN:     if (!enable) r_state <= w_pending ? DRAIN : IDLE;
                DRAIN: begin
                    if (enable)          r_state <= RUN;
                    else if (!w_pending) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer  <= '0;
            r_stall <= '0;
        end else begin
            if (w_pop && (r_xfer != '1)) begin
                r_xfer <= r_xfer + 1'b1;
            end
            if (m_valid && !m_ready && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign xfer_cnt  = r_xfer;
    assign stall_cnt = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_streamer
// Description : Self-checking bench. A queue-based FIFO feeds the design; a
//               queue-based model of the stream buffer predicts every output
//               each cycle. A second instance with 4-bit counters shares the
//               stimulus to exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_streamer;

    localparam int DW    = 8;
    localparam int CNT_W = 16;
    localparam int CNT4  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          m_ready;

    wire             fifo_re, m_valid, busy;
    wire [DW-1:0]    m_data;
    wire [CNT_W-1:0] xfer_cnt, stall_cnt;
    wire             re4, valid4, busy4;
    wire [DW-1:0]    data4;
    wire [CNT4-1:0]  xfer4, stall4;

    fifo_rd_streamer #(.DW(DW), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_re(fifo_re),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
        .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
    );

    fifo_rd_streamer #(.DW(DW), .CNT_W(CNT4)) u_dut4 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_re(re4),
        .m_valid(valid4), .m_ready(m_ready), .m_data(data4), .busy(busy4),
        .xfer_cnt(xfer4), .stall_cnt(stall4)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- FIFO model (1-cycle read latency) ----------------
    logic [DW-1:0] fifo_q[$];

    always @(posedge clk) begin
        if (fifo_re && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    end

    // ---------------- behavioural model of the streamer ----------------
    logic [DW-1:0] mq[$];
    bit            m_infl;
    logic [DW-1:0] m_iw;
    int            m_st;      // 0 idle, 1 run, 2 drain
    longint        m_x, m_s;
    int            cyc = 0;

    // observations for the directed checks
    int            re_cnt = 0;
    int            first_re = -1, first_v = -1;
    logic [DW-1:0] obs_d[$];
    int            obs_c[$];

    function automatic logic [31:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return 32'((v > mx) ? mx : v);
    endfunction

    always @(negedge clk) begin
        bit ev, pop, er;
        int lvl;
        cyc++;
        if (rst) begin
            mq.delete(); m_infl = 0; m_st = 0; m_x = 0; m_s = 0;
            check($sformatf("rst fifo_re@%0d", cyc), 32'(fifo_re), 0);
            check($sformatf("rst m_valid@%0d", cyc), 32'(m_valid), 0);
            check($sformatf("rst m_data@%0d", cyc), 32'(m_data), 0);
            check($sformatf("rst xfer@%0d", cyc), 32'(xfer_cnt), 0);
        end else begin
            ev  = (mq.size() != 0);
            pop = ev && m_ready;
            lvl = mq.size() + int'(m_infl);
            er  = enable && !flush && !fifo_empty && (lvl - int'(pop) < 2);

            check($sformatf("fifo_re@%0d", cyc), 32'(fifo_re), 32'(er));
            check($sformatf("m_valid@%0d", cyc), 32'(m_valid), 32'(ev));
            if (ev) check($sformatf("m_data@%0d", cyc), 32'(m_data), 32'(mq[0]));
            check($sformatf("busy@%0d", cyc), 32'(busy), 32'(m_st != 0));
            check($sformatf("xfer_cnt@%0d", cyc), 32'(xfer_cnt), sat(m_x, CNT_W));
            check($sformatf("stall_cnt@%0d", cyc), 32'(stall_cnt), sat(m_s, CNT_W));
            check($sformatf("xfer_cnt4@%0d", cyc), 32'(xfer4), sat(m_x, CNT4));
            check($sformatf("stall_cnt4@%0d", cyc), 32'(stall4), sat(m_s, CNT4));
            check($sformatf("dup@%0d", cyc), {re4, valid4, busy4, data4},
                  {fifo_re, m_valid, busy, m_data});

            if (fifo_re) re_cnt++;
            if (fifo_re && first_re < 0) first_re = cyc;
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                obs_d.push_back(m_data);
                obs_c.push_back(cyc);
            end

            // advance the model across the coming edge
            if (pop) m_x++;
            if (ev && !m_ready) m_s++;
            if (pop) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (m_infl) mq.push_back(m_iw);
            m_infl = er;
            if (er && fifo_q.size() > 0) m_iw = fifo_q[0];

            if (flush) m_st = enable ? 1 : 0;
            else if (m_st == 0) begin
                if (enable) m_st = 1;
            end else if (m_st == 1) begin
                if (!enable) m_st = (lvl > 0) ? 2 : 0;
            end else begin
                if (enable) m_st = 1;
                else if (lvl == 0) m_st = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_c.delete();
        first_re = -1; first_v = -1; re_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fifo_q.delete(); fifo_empty = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear_obs();
    endtask

    initial begin
        int k;
        int snap;
        rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0;
        tick(); tick();
        check("reset fifo_re", 32'(fifo_re), 0);
        check("reset m_valid", 32'(m_valid), 0);
        check("reset m_data", 32'(m_data), 0);
        check("reset busy", 32'(busy), 0);
        check("reset stall_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;

        // Streaming 0x01..0x08 at full rate
        do_reset();
        for (int v = 1; v <= 8; v++) push(DW'(v));
        m_ready = 1'b1; enable = 1'b1;
        k = 0;
        while (obs_d.size() < 8 && k < 40) begin tick(); k++; end
        check("stream count", 32'(obs_d.size()), 8);
        check("first latency", 32'(first_v - first_re), 2);
        for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
            check($sformatf("stream data[%0d]", i), 32'(obs_d[i]), 32'(i + 1));
            check($sformatf("stream cycle[%0d]", i), 32'(obs_c[i]), 32'(first_re + 2 + i));
        end
        tick();
        check("stream xfer_cnt", 32'(xfer_cnt), 8);

        // Stall: ten cycles of valid with ready low
        do_reset();
        for (int v = 0; v < 4; v++) push(8'hA0 + DW'(v));
        m_ready = 1'b0; enable = 1'b1;
        k = 0;
        while (first_v < 0 && k < 20) begin tick(); k++; end
        check("stall valid seen", 32'(first_v >= 0), 1);
        repeat (9) tick();
        check("stall re pulses", 32'(re_cnt), 2);
        check("stall cnt", 32'(stall_cnt), 10);
        check("stall head", 32'(m_data), 32'hA0);
        m_ready = 1'b1;
        k = 0;
        while (obs_d.size() < 4 && k < 20) begin tick(); k++; end
        check("stall count", 32'(obs_d.size()), 4);
        for (int i = 0; i < 4 && i < obs_d.size(); i++)
            check($sformatf("stall data[%0d]", i), 32'(obs_d[i]), 32'hA0 + 32'(i));

        // Drain after enable falls with a full buffer
        do_reset();
        for (int v = 0; v < 6; v++) push(8'h30 + DW'(v));
        m_ready = 1'b0; enable = 1'b1;
        repeat (6) tick();
        check("drain pre valid", 32'(m_valid), 1);
        enable = 1'b0; m_ready = 1'b1;
        clear_obs();
        tick();
        check("drain busy", 32'(busy), 1);
        repeat (5) tick();
        check("drain count", 32'(obs_d.size()), 2);
        check("drain re", 32'(re_cnt), 0);
        check("drain idle", 32'(busy), 0);
        if (obs_d.size() == 2) begin
            check("drain d0", 32'(obs_d[0]), 32'h30);
            check("drain d1", 32'(obs_d[1]), 32'h31);
        end

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 700; i++) begin
            tick();
            enable  = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 29) == 0);
            if (fifo_q.size() < 6) begin
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) push(DW'($urandom));
            end
            if (i == 350) begin
                check("sat4 before reset", 32'(xfer4), 32'hF);
                #2;
                rst = 1'b1;
                #1;
                check("async fifo_re", 32'(fifo_re), 0);
                check("async m_valid", 32'(m_valid), 0);
                check("async m_data", 32'(m_data), 0);
                check("async busy", 32'(busy), 0);
                check("async xfer", 32'(xfer_cnt), 0);
                check("async stall", 32'(stall_cnt), 0);
                tick(); tick();
                rst = 1'b0;
            end
        end
        flush = 1'b0; enable = 1'b0; m_ready = 1'b1;
        repeat (4) tick();
        check("sat4 final", 32'(xfer4), 32'hF);
        snap = int'(xfer_cnt);
        check("xfer beyond sat", 32'(snap > 15), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
